jump_trajectory_gen: RTL and testbench

Parametrised jump-trajectory address generator for the dinosaur sprite. On a jump-button press it walks an address from 0 to `TABLE_DEPTH-1` at one step per `TICK_DIV` clocks, then lands and returns to 0. The downstream jump-height ROM uses the address to index its y-offset. The block sits between the debounced button/game-control logic and the jump ROM, and adds edge-triggered starts, automatic landing, status flags and an optional jump buffer.

---
 rtl/jump_trajectory_gen_if.sv | 46 ++++
 rtl/jump_trajectory_gen.sv | 184 ++++++++++++++++++
 tb/tb_jump_trajectory_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jump_trajectory_gen_if.sv
// ---------------------------------------------------------------------------
// jump_trajectory_gen_if
//
// Groups the game-control inputs and trajectory outputs of the jump
// trajectory generator. Clock and reset stay plain ports on the module.
//
// Signals:
//   gs        game started; 0 forces the generator to the ground state
//   halt      freeze (game over / pause)
//   button    debounced jump button, level
//   movaddr   trajectory ROM address (ADDR_W bits)
//   airborne  high while a jump is in progress
//   jump_done one-cycle pulse on landing
//
// Modports:
//   master  game-control side: drives gs/halt/button, observes the outputs
//   slave   generator side: receives gs/halt/button, drives the outputs
// ---------------------------------------------------------------------------
interface jump_trajectory_gen_if #(
    parameter int ADDR_W = 10
);
    logic              gs;
    logic              halt;
    logic              button;
    logic [ADDR_W-1:0] movaddr;
    logic              airborne;
    logic              jump_done;

    modport master (
        output gs,
        output halt,
        output button,
        input  movaddr,
        input  airborne,
        input  jump_done
    );

    modport slave (
        input  gs,
        input  halt,
        input  button,
        output movaddr,
        output airborne,
        output jump_done
    );
endinterface

// File: rtl/jump_trajectory_gen.sv
// ---------------------------------------------------------------------------
// jump_trajectory_gen
//
// Jump-trajectory address generator for the dinosaur sprite. A rising edge
// on the jump button launches a jump: movaddr walks 0..TABLE_DEPTH-1, one
// step every TICK_DIV clocks, then the sprite lands, movaddr returns to 0
// and jump_done pulses for one cycle. All outputs are registered.
//
// Priority (highest first): reset=0, gs=0, halt=1, normal operation.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low reset
//   bus    jump_trajectory_gen_if.slave (gs, halt, button in;
//          movaddr, airborne, jump_done out)
//
// Parameters:
//   ADDR_W       width of movaddr (TABLE_DEPTH <= 2**ADDR_W)
//   TABLE_DEPTH  number of trajectory entries (2..2**ADDR_W)
//   TICK_DIV     clocks per address step (>= 2)
//   BUF_WINDOW   number of final steps in which a press is buffered
//
// Optional feature, macro JUMP_BUFFER_EN:
//   When defined, a press during the last BUF_WINDOW steps of a jump is
//   remembered and the sprite relaunches immediately on landing (jump_done
//   still pulses, airborne stays high). When undefined, every press while
//   airborne is dropped and no buffer register exists.
// ---------------------------------------------------------------------------
module jump_trajectory_gen #(
    parameter int ADDR_W      = 10,
    parameter int TABLE_DEPTH = 51,
    parameter int TICK_DIV    = 251251,
    parameter int BUF_WINDOW  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    jump_trajectory_gen_if.slave  bus
);

    localparam int TICK_W = $clog2(TICK_DIV);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TABLE_DEPTH - 1);

    // Elaboration-time guard on the legal parameter ranges.
    if (TICK_DIV < 2 || TABLE_DEPTH < 2 || TABLE_DEPTH > (1 << ADDR_W) ||
        BUF_WINDOW < 1 || BUF_WINDOW > TABLE_DEPTH - 1) begin : g_param_check
        $error("jump_trajectory_gen: illegal parameter combination");
    end

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } state_t;

    state_t            state_reg,     state_next;
    logic [TICK_W-1:0] tick_reg,      tick_next;
    logic [ADDR_W-1:0] movaddr_reg,   movaddr_next;
    logic              airborne_reg,  airborne_next;
    logic              jump_done_reg, jump_done_next;
    logic              btn_q_reg,     btn_q_next;

`ifdef JUMP_BUFFER_EN
    // First address at which a press is buffered for an immediate relaunch.
    localparam logic [ADDR_W-1:0] BUF_START = ADDR_W'(TABLE_DEPTH - BUF_WINDOW);

    logic              buf_reg,       buf_next;
`endif

    logic press;

    // Rising edge of the level button; btn_q follows the button every cycle,
    // even while halted, so a button held through a pause never fires.
    assign press = bus.button & ~btn_q_reg;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= GROUND;
            tick_reg      <= '0;
            movaddr_reg   <= '0;
            airborne_reg  <= 1'b0;
            jump_done_reg <= 1'b0;
            btn_q_reg     <= bus.button;
`ifdef JUMP_BUFFER_EN
            buf_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            movaddr_reg   <= movaddr_next;
            airborne_reg  <= airborne_next;
            jump_done_reg <= jump_done_next;
            btn_q_reg     <= btn_q_next;
`ifdef JUMP_BUFFER_EN
            buf_reg       <= buf_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        tick_next      = tick_reg;
        movaddr_next   = movaddr_reg;
        airborne_next  = airborne_reg;
        jump_done_next = 1'b0;          // pulse; also forced low during halt
        btn_q_next     = bus.button;
`ifdef JUMP_BUFFER_EN
        buf_next       = buf_reg;
`endif

        if (!bus.gs) begin
            // Game not running: silently abort any jump, no landing pulse.
            state_next    = GROUND;
            tick_next     = '0;
            movaddr_next  = '0;
            airborne_next = 1'b0;
`ifdef JUMP_BUFFER_EN
            buf_next      = 1'b0;
`endif
        end else if (!bus.halt) begin
            case (state_reg)
                GROUND: begin
                    movaddr_next = '0;
                    if (press) begin
                        state_next    = AIR;
                        tick_next     = '0;
                        airborne_next = 1'b1;
                    end
                end

                AIR: begin
`ifdef JUMP_BUFFER_EN
                    // The landing decision below reads buf_next, so a press
                    // in the landing cycle itself (still inside the window)
                    // also triggers the relaunch.
                    if (press && movaddr_reg >= BUF_START) begin
                        buf_next = 1'b1;
                    end
`endif
                    if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                        if (movaddr_reg != ADDR_LAST) begin
                            movaddr_next = movaddr_reg + ADDR_W'(1);
                        end else begin
                            movaddr_next   = '0;
                            jump_done_next = 1'b1;
`ifdef JUMP_BUFFER_EN
                            if (buf_next) begin
                                // Relaunch straight away; airborne stays high.
                                state_next    = AIR;
                                airborne_next = 1'b1;
                                buf_next      = 1'b0;
                            end else begin
                                state_next    = GROUND;
                                airborne_next = 1'b0;
                            end
`else
                            state_next    = GROUND;
                            airborne_next = 1'b0;
`endif
                        end
                    end else begin
                        tick_next = tick_reg + TICK_W'(1);
                    end
                end

                default: begin
                    state_next = GROUND;
                end
            endcase
        end
    end

    assign bus.movaddr   = movaddr_reg;
    assign bus.airborne  = airborne_reg;
    assign bus.jump_done = jump_done_reg;

endmodule

// File: tb/tb_jump_trajectory_gen.sv
// ---------------------------------------------------------------------------
// tb_jump_trajectory_gen
//
// Directed bench for jump_trajectory_gen with TICK_DIV=4, TABLE_DEPTH=5,
// BUF_WINDOW=2. A behavioural model tracks the jump as "clocks spent in the
// air" (address = elapsed / TICK_DIV, landing at TABLE_DEPTH*TICK_DIV) and is
// compared against the DUT on every falling edge; scenario code adds literal
// expectations at hand-computed cycle offsets.
// ---------------------------------------------------------------------------
module tb_jump_trajectory_gen;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 5;
    localparam int TICK   = 4;
    localparam int BUFW   = 2;

`ifdef JUMP_BUFFER_EN
    localparam int BUF_EN = 1;
`else
    localparam int BUF_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    jump_trajectory_gen_if #(.ADDR_W(ADDR_W)) jif ();

    jump_trajectory_gen #(
        .ADDR_W      (ADDR_W),
        .TABLE_DEPTH (DEPTH),
        .TICK_DIV    (TICK),
        .BUF_WINDOW  (BUFW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (jif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    int m_elapsed = 0;   // clocks spent in the air in the current jump
    bit m_jump    = 0;
    bit m_prev    = 0;
    bit m_buf     = 0;
    bit m_done    = 0;
    bit chk_en    = 0;

    always @(posedge clk) begin
        bit pressed;
        pressed = 0;
        if (!reset || !jif.gs) begin
            m_jump    = 0;
            m_elapsed = 0;
            m_buf     = 0;
            m_done    = 0;
            m_prev    = jif.button;
        end else begin
            pressed = jif.button && !m_prev;
            m_prev  = jif.button;
            m_done  = 0;
            if (!jif.halt) begin
                if (!m_jump) begin
                    if (pressed) begin
                        m_jump    = 1;
                        m_elapsed = 0;
                    end
                end else begin
                    if (BUF_EN != 0 && pressed && (m_elapsed / TICK) >= DEPTH - BUFW)
                        m_buf = 1;
                    m_elapsed++;
                    if (m_elapsed == DEPTH * TICK) begin
                        m_done    = 1;
                        m_elapsed = 0;
                        if (m_buf) m_buf = 0;
                        else       m_jump = 0;
                    end
                end
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("movaddr",   int'(jif.movaddr),   m_jump ? m_elapsed / TICK : 0);
            check("airborne",  int'(jif.airborne),  int'(m_jump));
            check("jump_done", int'(jif.jump_done), int'(m_done));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle press: the rising button is sampled at the next edge (N).
    task automatic press_once();
        jif.button = 1'b1;
        step();
        jif.button = 1'b0;
    endtask

    initial begin
        int cnt;
        int waited;

        reset      = 1'b0;
        jif.gs     = 1'b1;
        jif.halt   = 1'b0;
        jif.button = 1'b0;

        // Reset, then idle.
        steps(3);
        check("reset_movaddr", int'(jif.movaddr), 0);
        check("reset_airborne", int'(jif.airborne), 0);
        reset = 1'b1;
        steps(30);
        check("idle_airborne", int'(jif.airborne), 0);
        $display("TXN reset+idle: movaddr=%0d airborne=%0d", jif.movaddr, jif.airborne);

        // Single press: steps at N+4/8/12/16, landing at N+20.
        press_once();
        check("press_airborne_n1", int'(jif.airborne), 1);
        check("press_movaddr_n1", int'(jif.movaddr), 0);
        steps(3);
        check("movaddr_n3", int'(jif.movaddr), 0);
        step();
        check("movaddr_n4", int'(jif.movaddr), 1);
        steps(12);
        check("movaddr_n16", int'(jif.movaddr), 4);
        steps(3);
        check("done_n19", int'(jif.jump_done), 0);
        step();
        check("land_movaddr_n20", int'(jif.movaddr), 0);
        check("land_airborne_n20", int'(jif.airborne), 0);
        check("land_done_n20", int'(jif.jump_done), 1);
        step();
        check("done_n21", int'(jif.jump_done), 0);
        $display("TXN single jump: landed, jump_done cleared");

        // Button held for 40 cycles: exactly one jump.
        cnt = 0;
        jif.button = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (jif.jump_done) cnt++;
        end
        jif.button = 1'b0;
        check("held_pulses", cnt, 1);
        check("held_airborne_end", int'(jif.airborne), 0);
        step();
        $display("TXN held button: %0d landing pulse(s)", cnt);

        // Halt 10 cycles at movaddr=2 with a press inside the halt.
        press_once();
        steps(8);
        check("halt_pre_movaddr", int'(jif.movaddr), 2);
        step();
        jif.halt   = 1'b1;
        jif.button = 1'b1;
        steps(5);
        check("halt_mid_movaddr", int'(jif.movaddr), 2);
        check("halt_mid_done", int'(jif.jump_done), 0);
        steps(5);
        check("halt_end_movaddr", int'(jif.movaddr), 2);
        jif.halt = 1'b0;
        waited = 0;
        while (!jif.jump_done && waited < 40) begin
            step();
            waited++;
        end
        jif.button = 1'b0;
        check("halt_landing_edge", 19 + waited, 30);
        step();
        steps(4);
        check("halt_no_retrigger", int'(jif.airborne), 0);
        $display("TXN halt: landing at N+%0d", 19 + waited);

        // gs dropped at movaddr=3.
        press_once();
        steps(12);
        check("gs_pre_movaddr", int'(jif.movaddr), 3);
        jif.gs = 1'b0;
        step();
        check("gs_movaddr", int'(jif.movaddr), 0);
        check("gs_airborne", int'(jif.airborne), 0);
        check("gs_done", int'(jif.jump_done), 0);
        jif.gs = 1'b1;
        steps(25);
        check("gs_after_airborne", int'(jif.airborne), 0);
        $display("TXN gs drop: jump aborted");

        // Reset asserted at movaddr=3.
        press_once();
        steps(12);
        check("rst_pre_movaddr", int'(jif.movaddr), 3);
        reset = 1'b0;
        step();
        check("rst_movaddr", int'(jif.movaddr), 0);
        check("rst_airborne", int'(jif.airborne), 0);
        check("rst_done", int'(jif.jump_done), 0);
        reset = 1'b1;
        steps(25);
        $display("TXN mid-jump reset: jump aborted");

        // Press at movaddr=3 (inside the buffer window).
        press_once();
        steps(12);
        check("buf_pre_movaddr", int'(jif.movaddr), 3);
        press_once();                       // sampled at N+13
        steps(7);                           // now after N+20
        check("buf_land_done", int'(jif.jump_done), 1);
        check("buf_land_airborne", int'(jif.airborne), BUF_EN);
        check("buf_land_movaddr", int'(jif.movaddr), 0);
        steps(4);
        check("buf_relaunch_movaddr", int'(jif.movaddr), BUF_EN);
        steps(20);
        $display("TXN late press: relaunch=%0d", BUF_EN);

        // Press at movaddr=1 (outside the window): always ignored.
        press_once();
        steps(4);
        check("early_pre_movaddr", int'(jif.movaddr), 1);
        press_once();                       // sampled at N+5
        steps(15);                          // now after N+20
        check("early_land_done", int'(jif.jump_done), 1);
        check("early_land_airborne", int'(jif.airborne), 0);
        steps(5);
        $display("TXN early press: ignored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
